mem_bus_arbiter: RTL

Two-requester memory arbiter that shares the CPU's single external memory bus between the instruction-fetch path and the load/store data path of the multicycle core. It latches one request at a time, drives a read or write onto a waitrequest-style bus, holds it until the bus accepts, and returns a one-cycle acknowledge with registered read data. The control FSM stalls on the acknowledge; this block owns all bus sequencing.

---
 rtl/mem_bus_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one waitrequest-style memory bus between the fetch and load/store paths.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data always beats fetch.
module mem_bus_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_byteen,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic [AW-1:0]   bus_addr,
    output logic            bus_read,
    output logic            bus_write,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_byteenable,
    input  logic            bus_waitrequest,
    input  logic [DW-1:0]   bus_readdata,
    output logic            busy,
    output logic            owner
);

    localparam int              BW        = DW / 8;
    localparam logic [AW-1:0]   ADDR_MASK = ~AW'(BW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_grant;
    logic            w_grant_data;
    logic            w_accept;

    logic [AW-1:0]   r_bus_addr;
    logic            r_bus_read;
    logic            r_bus_write;
    logic [DW-1:0]   r_bus_wdata;
    logic [BW-1:0]   r_bus_byteenable;
    logic [DW-1:0]   r_rdata;
    logic            r_if_ack;
    logic            r_d_ack;
    logic            r_owner;

`ifdef MEM_ARB_RR_EN
    logic            r_rr_last;

    // On a tie the requester that did not win last time goes next.
    always_comb w_grant_data = d_req && !(if_req && r_rr_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rr_last <= 1'b0;
        else if (w_grant)
            r_rr_last <= w_grant_data;
    end
`else
    always_comb w_grant_data = d_req;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_req || d_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUS;
                end
            end
            S_BUS: begin
                if (!bus_waitrequest) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_addr       <= '0;
            r_bus_read       <= 1'b0;
            r_bus_write      <= 1'b0;
            r_bus_wdata      <= '0;
            r_bus_byteenable <= '0;
            r_rdata          <= '0;
            r_if_ack         <= 1'b0;
            r_d_ack          <= 1'b0;
            r_owner          <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            if (w_grant) begin
                r_owner          <= w_grant_data;
                r_bus_addr       <= (w_grant_data ? d_addr : if_addr) & ADDR_MASK;
                r_bus_byteenable <= w_grant_data ? d_byteen : '1;
                r_bus_read       <= !(w_grant_data && d_we);
                r_bus_write      <= w_grant_data && d_we;
                if (w_grant_data)
                    r_bus_wdata <= d_wdata;
            end
            if (w_accept) begin
                r_bus_read  <= 1'b0;
                r_bus_write <= 1'b0;
                if (r_bus_read)
                    r_rdata <= bus_readdata;
                r_if_ack <= !r_owner;
                r_d_ack  <= r_owner;
            end
        end
    end

    assign bus_addr       = r_bus_addr;
    assign bus_read       = r_bus_read;
    assign bus_write      = r_bus_write;
    assign bus_wdata      = r_bus_wdata;
    assign bus_byteenable = r_bus_byteenable;
    assign if_ack         = r_if_ack;
    assign d_ack          = r_d_ack;
    assign if_rdata       = r_rdata;
    assign d_rdata        = r_rdata;
    assign owner          = r_owner;
    assign busy           = (r_state != S_IDLE);

endmodule
